// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential shift-and-add-3 binary-to-BCD converter with a start/busy/done handshake.
// Optional leading-zero blanking is enabled by the BCD_BLANK_EN macro.
`default_nettype none

module bin_to_bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [BIN_W-1:0]      i_data_bin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_data_bcd,
  output logic                  o_ovf,
  output logic [DIGITS-1:0]     o_blank
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state, state_d;
  logic [BIN_W-1:0]   sh, sh_d;
  logic [BCD_W-1:0]   bcd, bcd_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               ovf_w, ovf_w_d;
  logic               done_d;
  logic [BCD_W-1:0]   data_d;
  logic               ovf_d;

  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   shifted;
  logic               out_bit;
  logic               last_shift;

  // Per-digit add-3 correction; a 4-bit add, digits never carry into each other.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    always_comb begin
      adj[4*i +: 4] = bcd[4*i +: 4];
      if (bcd[4*i +: 4] > 4'd4)
        adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  assign shifted    = {adj[BCD_W-2:0], sh[BIN_W-1]};
  assign out_bit    = adj[BCD_W-1];
  assign last_shift = (state == SHIFT) && (cnt == LAST_CNT);
  assign o_busy     = (state != IDLE);

  always_comb begin
    state_d = state;
    sh_d    = sh;
    bcd_d   = bcd;
    cnt_d   = cnt;
    ovf_w_d = ovf_w;
    done_d  = 1'b0;
    data_d  = o_data_bcd;
    ovf_d   = o_ovf;
    case (state)
      IDLE: begin
        if (i_start) begin
          sh_d    = i_data_bin;
          bcd_d   = '0;
          ovf_w_d = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sh_d    = {sh[BIN_W-2:0], 1'b0};
        bcd_d   = shifted;
        ovf_w_d = ovf_w | out_bit;
        cnt_d   = cnt + 1'b1;
        if (cnt == LAST_CNT) begin
          data_d  = shifted;
          ovf_d   = ovf_w | out_bit;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sh         <= '0;
      bcd        <= '0;
      cnt        <= '0;
      ovf_w      <= 1'b0;
      o_done     <= 1'b0;
      o_data_bcd <= '0;
      o_ovf      <= 1'b0;
    end else begin
      state      <= state_d;
      sh         <= sh_d;
      bcd        <= bcd_d;
      cnt        <= cnt_d;
      ovf_w      <= ovf_w_d;
      o_done     <= done_d;
      o_data_bcd <= data_d;
      o_ovf      <= ovf_d;
    end
  end

`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0] hi_zero;
  logic [DIGITS-1:0] blank_new;

  // hi_zero[i]: digit i and every digit above it are zero in the incoming result.
  for (genvar i = 0; i < DIGITS; i++) begin : g_blank
    if (i == DIGITS - 1) begin : g_top
      assign hi_zero[i] = (shifted[4*i +: 4] == 4'd0);
    end else begin : g_mid
      assign hi_zero[i] = (shifted[4*i +: 4] == 4'd0) && hi_zero[i+1];
    end
  end

  assign blank_new = {hi_zero[DIGITS-1:1], 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_blank <= '0;
    end else if (last_shift) begin
      o_blank <= (ovf_w | out_bit) ? '0 : blank_new;
    end
  end
`else
  assign o_blank = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq (BIN_W=14, DIGITS=4).
`default_nettype none

module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst;
  logic        i_start;
  logic [13:0] i_data_bin;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_data_bcd;
  logic        o_ovf;
  logic [3:0]  o_blank;

  int n_checks = 0;
  int n_fail   = 0;

  bin_to_bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_data_bin (i_data_bin),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_data_bcd (o_data_bcd),
    .o_ovf      (o_ovf),
    .o_blank    (o_blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decimal reference: low four digits of v, packed BCD.
  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [3:0] exp_blank(input int v);
    logic [3:0] b;
    logic       hz;
    b = 4'b0000;
`ifdef BCD_BLANK_EN
    if (v < 10000) begin
      hz = 1'b1;
      for (int i = 3; i >= 1; i--) begin
        hz   = hz && (((v / (10 ** i)) % 10) == 0);
        b[i] = hz;
      end
    end
`else
    hz = 1'b0;
    b  = {3'b000, hz};
`endif
    return b;
  endfunction

  // Call at posedge+1 with the DUT idle.
  task automatic convert(input string tag, input int v);
    logic [15:0] eb;
    logic        eo;
    logic [3:0]  ebl;
    logic        early;
    eb  = to_bcd(v);
    eo  = (v >= 10000);
    ebl = exp_blank(v);
    i_data_bin = 14'(v);
    i_start    = 1'b1;
    @(posedge clk); #1;
    i_start    = 1'b0;
    i_data_bin = ~14'(v);
    early = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      if (k < 14 && o_done) early = 1'b1;
    end
    check({tag, " early_done"}, 32'(early), 32'd0);
    check({tag, " done"},  32'(o_done),     32'd1);
    check({tag, " bcd"},   32'(o_data_bcd), 32'(eb));
    check({tag, " ovf"},   32'(o_ovf),      32'(eo));
    check({tag, " blank"}, 32'(o_blank),    32'(ebl));
    check({tag, " busy"},  32'(o_busy),     32'd1);
    @(posedge clk); #1;
    check({tag, " done_fall"}, 32'(o_done),     32'd0);
    check({tag, " idle"},      32'(o_busy),     32'd0);
    check({tag, " hold"},      32'(o_data_bcd), 32'(eb));
  endtask

  initial begin
    logic       seen;
    logic [2:0] ebl0;
    int         v;
    int         vals [32];

    rst        = 1'b1;
    i_start    = 1'b0;
    i_data_bin = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy",  32'(o_busy),     32'd0);
    check("rst done",  32'(o_done),     32'd0);
    check("rst bcd",   32'(o_data_bcd), 32'd0);
    check("rst ovf",   32'(o_ovf),      32'd0);
    check("rst blank", 32'(o_blank),    32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Hand-computed directed vectors.
    convert("zero", 0);
`ifdef BCD_BLANK_EN
    check("zero blank_const", 32'(o_blank), 32'h0000_000E);
`endif
    convert("v9999",  9999);
    check("v9999 const",  32'(o_data_bcd), 32'h0000_9999);
    convert("v1234",  1234);
    check("v1234 const",  32'(o_data_bcd), 32'h0000_1234);
    convert("v42",    42);
    check("v42 const",    32'(o_data_bcd), 32'h0000_0042);
    convert("v10000", 10000);
    check("v10000 const", 32'(o_data_bcd), 32'h0000_0000);
    check("v10000 ovf",   32'(o_ovf),      32'd1);
    convert("v16383", 16383);
    check("v16383 const", 32'(o_data_bcd), 32'h0000_6383);
    check("v16383 ovf",   32'(o_ovf),      32'd1);
    convert("v9", 9);
    convert("v100", 100);

    // i_start held high with changing data: accepts at hold edges 0 and 16.
    for (int j = 0; j < 32; j++) vals[j] = (j * 1237 + 301) % 16384;
    for (int j = 0; j < 32; j++) begin
      i_data_bin = 14'(vals[j]);
      i_start    = (j < 30);
      @(posedge clk); #1;
      check("hold done", 32'(o_done), 32'((j == 14) || (j == 30)));
      if (j == 14 || j == 30) begin
        check("hold bcd", 32'(o_data_bcd), 32'(to_bcd(vals[j-14])));
        check("hold ovf", 32'(o_ovf),      32'(vals[j-14] >= 10000));
      end
    end
    i_start = 1'b0;
    @(posedge clk); #1;

    // Reset five cycles into a conversion.
    i_data_bin = 14'd4321;
    i_start    = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    check("abort busy",  32'(o_busy),     32'd0);
    check("abort done",  32'(o_done),     32'd0);
    check("abort bcd",   32'(o_data_bcd), 32'd0);
    check("abort ovf",   32'(o_ovf),      32'd0);
    check("abort blank", 32'(o_blank),    32'd0);
    @(posedge clk); #1;
    rst  = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (o_done) seen = 1'b1;
    end
    check("abort no_done", 32'(seen), 32'd0);
    convert("after_abort", 4321);

    // Strided sweep against the decimal reference.
    v = 0;
    while (v <= 16383) begin
      convert("sweep", v);
      v = v + 389;
    end
    convert("sweep_top", 16383);
    ebl0 = 3'b000;
    check("sweep blank0", 32'(o_blank[0]), 32'(ebl0[0]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
